// File: rtl/encoder_rr_share_pkg.sv
// Shared types and sizing helpers for the round-robin shared encoder.
package encoder_rr_share_pkg;

    localparam int unsigned NInDefault  = 4;
    localparam int unsigned NOutDefault = 4;
    localparam int unsigned NReqDefault = 4;

    // Requester index width; never below one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IdWDefault = id_w(NReqDefault);

    typedef logic [IdWDefault-1:0] id_t;
    typedef logic [NInDefault-1:0] operand_t;

endpackage

// File: rtl/encoder_rr_share_if.sv
// Request/response bundle between requesters, consumer and the shared encoder.
interface encoder_rr_share_if
    import encoder_rr_share_pkg::*;
#(
    parameter int unsigned N_IN  = NInDefault,
    parameter int unsigned N_OUT = NOutDefault,
    parameter int unsigned N_REQ = NReqDefault,
    parameter int unsigned ID_W  = id_w(N_REQ)
) ();

    logic [N_REQ-1:0]      req_valid_i;
    logic [N_REQ-1:0]      req_ready_o;
    logic [N_REQ*N_IN-1:0] req_operand_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [N_OUT-1:0]      rsp_result_o;
    logic [ID_W-1:0]       rsp_id_o;

    modport master (
        output req_valid_i, req_operand_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
    );

    modport slave (
        input  req_valid_i, req_operand_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
    );

endinterface

// File: rtl/encoder_rr_share_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above the pointer, wrapping once.
module encoder_rr_share_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic           found;

    // Upper copy of req covers the wrap, so a single upward scan from the pointer suffices.
    always_comb begin
        dbl     = {req, req};
        mask    = '0;
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < 2 * N; i++) begin
            mask[i] = (i >= int'(pointer));
        end
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i] && mask[i]) begin
                found   = 1'b1;
                gnt_idx = IW'(i % N);
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mydesign_comb.sv
// Combinational encoder core under exploration; this build maps the operand to its Gray code,
// truncated or zero-extended to N_OUT bits.
module mydesign_comb #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 4
) (
    input  logic [N_IN-1:0]  data_i,
    output logic [N_OUT-1:0] data_o
);

    logic [N_IN-1:0] gray;

    assign gray   = data_i ^ (data_i >> 1);
    assign data_o = N_OUT'(gray);

endmodule

// File: rtl/encoder_rr_share.sv
// Shares one encoder core among N_REQ requesters: round-robin grant, operand stage (S1),
// output register stage (S2).
module encoder_rr_share
    import encoder_rr_share_pkg::*;
#(
    parameter int unsigned N_IN  = NInDefault,
    parameter int unsigned N_OUT = NOutDefault,
    parameter int unsigned N_REQ = NReqDefault,
    parameter int unsigned ID_W  = id_w(N_REQ)
) (
    input  logic                clk_ci,
    input  logic                rst_ni,
    input  logic                enable_i,
    encoder_rr_share_if.slave   bus,
    output logic                busy_o
);

    logic             s1_valid_q;
    logic [N_IN-1:0]  s1_operand_q;
    logic [ID_W-1:0]  s1_id_q;
    logic             s2_valid_q;
    logic [N_OUT-1:0] s2_result_q;
    logic [ID_W-1:0]  s2_id_q;
    logic [ID_W-1:0]  ptr_q;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_OUT-1:0] core_result;
    logic             adv2;
    logic             accept;

    assign adv2   = s1_valid_q & (~s2_valid_q | bus.rsp_ready_i);
    // rst_ni gating keeps every ready bit low while reset is held.
    assign accept = rst_ni & enable_i & (~s1_valid_q | adv2) & (|bus.req_valid_i);

    encoder_rr_share_rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .req     (bus.req_valid_i),
        .pointer (ptr_q),
        .en      (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    (* dont_touch = "true" *)
    mydesign_comb #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_core (
        .data_i (s1_operand_q),
        .data_o (core_result)
    );

    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_operand_q <= '0;
            s1_id_q      <= '0;
            ptr_q        <= '0;
        end else if (accept) begin
            s1_valid_q   <= 1'b1;
            s1_operand_q <= bus.req_operand_i[gnt_idx*N_IN +: N_IN];
            s1_id_q      <= gnt_idx;
            ptr_q        <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (adv2) begin
            s1_valid_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_id_q     <= '0;
        end else if (adv2) begin
            s2_valid_q  <= 1'b1;
            s2_result_q <= core_result;
            s2_id_q     <= s1_id_q;
        end else if (bus.rsp_ready_i) begin
            s2_valid_q  <= 1'b0;
        end
    end

    assign bus.req_ready_o  = gnt;
    assign bus.rsp_valid_o  = s2_valid_q;
    assign bus.rsp_result_o = s2_result_q;
    assign bus.rsp_id_o     = s2_id_q;
    assign busy_o           = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_encoder_rr_share.sv
// Bench for encoder_rr_share: queue-based reference model with a negedge monitor/scoreboard.
module tb_encoder_rr_share;
    import encoder_rr_share_pkg::*;

    localparam int unsigned NReq = 4;
    localparam int unsigned NIn  = 4;
    localparam int unsigned NOut = 4;
    localparam int unsigned IdW  = 2;

    logic clk_ci   = 1'b0;
    logic rst_ni   = 1'b0;
    logic enable_i = 1'b0;
    logic busy_o;

    always #5 clk_ci = ~clk_ci;

    encoder_rr_share_if #(.N_IN(NIn), .N_OUT(NOut), .N_REQ(NReq), .ID_W(IdW)) bus ();

    encoder_rr_share #(
        .N_IN  (NIn),
        .N_OUT (NOut),
        .N_REQ (NReq),
        .ID_W  (IdW)
    ) dut (
        .clk_ci   (clk_ci),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .bus      (bus),
        .busy_o   (busy_o)
    );

    typedef struct {
        operand_t op;
        int       id;
        int       acc;
    } item_t;

    item_t    q[$];
    int       checks    = 0;
    int       failures  = 0;
    int       edge_cnt  = 0;
    int       m_ptr     = 0;
    bit       final_chk = 1'b0;
    logic [3:0] vld     = '0;
    operand_t   ops[NReq];

    always @(posedge clk_ci) edge_cnt <= edge_cnt + 1;

    // Encoder reference: Gray code, b XOR floor(b/2).
    function automatic int golden(input operand_t x);
        int v;
        v = int'(x);
        return (v ^ (v / 2)) % (1 << NOut);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and model: outputs compared each cycle, then this cycle's pop/accept applied.
    always @(negedge clk_ci) begin
        logic [3:0] exp_rdy;
        bit         exp_v;
        bit         hit;
        int         g;
        item_t      it;
        if (final_chk) check("drain_empty", q.size(), 0);
        if (!rst_ni) begin
            check("rst_ready", int'(bus.req_ready_o), 0);
            check("rst_rsp_valid", int'(bus.rsp_valid_o), 0);
            check("rst_busy", int'(busy_o), 0);
            check("rst_result", int'(bus.rsp_result_o), 0);
            check("rst_id", int'(bus.rsp_id_o), 0);
            q.delete();
            m_ptr = 0;
        end else begin
            exp_v = (q.size() > 0) && (q[0].acc < edge_cnt);
            check("busy", int'(busy_o), int'(q.size() > 0));
            check("rsp_valid", int'(bus.rsp_valid_o), int'(exp_v));
            if (exp_v) begin
                check("rsp_result", int'(bus.rsp_result_o), golden(q[0].op));
                check("rsp_id", int'(bus.rsp_id_o), q[0].id);
            end
            exp_rdy = '0;
            g       = 0;
            hit     = 1'b0;
            if (enable_i && (|bus.req_valid_i) && (q.size() < 2 || bus.rsp_ready_i)) begin
                for (int s = 0; s < NReq; s++) begin
                    if (!hit && bus.req_valid_i[(m_ptr + s) % NReq]) begin
                        hit = 1'b1;
                        g   = (m_ptr + s) % NReq;
                    end
                end
                exp_rdy[g] = 1'b1;
            end
            check("req_ready", int'(bus.req_ready_o), int'(exp_rdy));
            if (exp_v && bus.rsp_ready_i) void'(q.pop_front());
            if (hit) begin
                it.op  = operand_t'(bus.req_operand_i[g*NIn +: NIn]);
                it.id  = g;
                it.acc = edge_cnt + 1;
                q.push_back(it);
                m_ptr = (g + 1) % NReq;
            end
        end
    end

    task automatic apply(input int rdy_mode, input int en_mode);
        bus.req_valid_i = vld;
        for (int k = 0; k < NReq; k++) bus.req_operand_i[k*NIn +: NIn] = ops[k];
        case (rdy_mode)
            0:       bus.rsp_ready_i = 1'b0;
            1:       bus.rsp_ready_i = 1'b1;
            default: bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
        endcase
        case (en_mode)
            0:       enable_i = 1'b0;
            1:       enable_i = 1'b1;
            default: enable_i = ($urandom_range(0, 4) != 0);
        endcase
    endtask

    // Requesters re-request after a grant; operands only change while not valid or just granted.
    task automatic run(input int cycles, input logic [3:0] active, input bit rand_ops,
                       input bit rand_valid, input int rdy_mode, input int en_mode);
        for (int c = 0; c < cycles; c++) begin
            logic [3:0] hs;
            @(negedge clk_ci);
            hs = bus.req_valid_i & bus.req_ready_o;
            @(posedge clk_ci);
            #1;
            for (int k = 0; k < NReq; k++) begin
                if (!active[k]) begin
                    vld[k] = 1'b0;
                end else if (hs[k] || !vld[k]) begin
                    ops[k] = rand_ops ? operand_t'($urandom) : operand_t'(k + 1);
                    vld[k] = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                end else if (rand_valid && $urandom_range(0, 3) == 0) begin
                    vld[k] = 1'b0;
                end
            end
            apply(rdy_mode, en_mode);
        end
    endtask

    task automatic single_req(input int k, input operand_t op);
        @(posedge clk_ci);
        #1;
        vld    = '0;
        vld[k] = 1'b1;
        ops[k] = op;
        apply(1, 1);
        run(1, 4'b0000, 1'b0, 1'b0, 1, 1);
    endtask

    initial begin
        for (int k = 0; k < NReq; k++) ops[k] = '0;
        apply(1, 0);
        repeat (3) @(negedge clk_ci);
        @(posedge clk_ci);
        #2;
        rst_ni = 1'b1;

        single_req(2, operand_t'(5));
        run(4, 4'b0000, 1'b0, 1'b0, 1, 1);

        run(12, 4'b1111, 1'b0, 1'b0, 1, 1);

        run(5, 4'b1111, 1'b0, 1'b0, 0, 1);
        run(6, 4'b1111, 1'b0, 1'b0, 1, 1);

        run(5, 4'b1111, 1'b0, 1'b0, 1, 0);
        run(6, 4'b1111, 1'b0, 1'b0, 1, 1);

        run(4, 4'b0000, 1'b0, 1'b0, 1, 1);
        single_req(2, operand_t'(9));
        run(8, 4'b1001, 1'b0, 1'b0, 1, 1);

        run(3, 4'b1111, 1'b0, 1'b0, 0, 1);
        @(posedge clk_ci);
        #2;
        rst_ni = 1'b0;
        @(negedge clk_ci);
        @(posedge clk_ci);
        #2;
        rst_ni = 1'b1;
        run(6, 4'b1111, 1'b0, 1'b0, 1, 1);

        run(400, 4'b1111, 1'b1, 1'b1, 2, 2);

        run(10, 4'b0000, 1'b0, 1'b0, 1, 1);
        @(posedge clk_ci);
        final_chk = 1'b1;
        @(negedge clk_ci);
        #1;
        final_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_rr_share.md
Name: encoder_rr_share

Overview:
- Shares one combinational encoder core (mydesign_comb, N_IN to N_OUT) between N_REQ requesters.
- Uses a round-robin arbiter, valid/ready handshakes and a 2-stage registered pipeline.
- Used in the encoding-exploration harness so several stimulus sources can drive one synthesised encoder instance.
- The core's dont_touch boundary is preserved: the core is instantiated exactly once with dont_touch.

Parameters:
- N_IN, 4, encoder operand width.
- N_OUT, 4, encoder result width.
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk_ci  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- enable_i  input  1  high: new grants allowed; low: no grants, in-flight data drains.
- req_valid_i  input  N_REQ  per-requester request valid.
- req_ready_o  output  N_REQ  per-requester accept; at most one bit high (one-hot grant).
- req_operand_i  input  N_REQ*N_IN  packed operands; requester k occupies bits [k*N_IN +: N_IN].
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumer ready.
- rsp_result_o  output  N_OUT  encoded result.
- rsp_id_o  output  ID_W  index of the requester that produced the response.
- busy_o  output  1  high while either pipeline stage holds data.

Behaviour:
- Reset, asynchronous and also applied mid-operation:
  - s1_valid, s2_valid, rsp_valid_o and busy_o go to 0.
  - rsp_result_o and rsp_id_o go to 0.
  - Round-robin pointer goes to 0; in-flight transactions are discarded.
  - req_ready_o is 0 during reset.
- Stage 1 (S1) registers operand and id. The core evaluates combinationally on the S1 operand.
- Stage 2 (S2) is the output register driving rsp_*.
- Advance conditions:
  - adv2 = s1_valid & (~s2_valid | rsp_ready_i).
  - accept = enable_i & (~s1_valid | adv2) & |req_valid_i.
- Grant:
  - Requester g = first k with req_valid_i[k], searching from pointer p upward with wrap modulo N_REQ.
  - req_ready_o[g] = accept; all other ready bits are 0.
  - req_ready_o depends combinationally on req_valid_i, rsp_ready_i and the state. Requesters must not make req_valid_i depend on req_ready_o.
- Pointer update:
  - On accept, p <= (g+1) mod N_REQ.
  - With no accept, p holds, including while stalled.
- Latency and throughput:
  - Handshake at edge t gives rsp_valid_o=1 after edge t+1, i.e. 2 cycles.
  - rsp_result_o = core(operand), with rsp_id_o = g.
  - Throughput is 1 per cycle when rsp_ready_i stays high.
- Backpressure (rsp_valid_o=1, rsp_ready_i=0):
  - rsp_result_o and rsp_id_o stay stable.
  - S1 holds; if S1 is full, all req_ready_o go to 0.
  - At most 2 transactions are in flight. No skid buffer.
- Response and pipeline updates:
  - Response completes on rsp_valid_o & rsp_ready_i.
  - If S1 is valid in the same cycle, S2 reloads and rsp_valid_o stays 1.
  - S1 loads on accept; S1 clears when adv2 occurs without accept.
- enable_i low:
  - No accepts and the pointer is frozen.
  - S1/S2 drain normally and busy_o falls once both are empty.
- Requester rules:
  - A requester may drop valid before being granted; it is then simply not considered.
  - A requester keeps its operand stable while valid is high.
- Fairness: with all N_REQ continuously valid, grants cycle 0,1,..,N_REQ-1,0; no requester waits more than N_REQ-1 accepts.

Decomposition:
- Package encoder_rr_share_pkg holds the default N_REQ, the ID_W function, and typedefs id_t and operand_t (logic [N_IN-1:0]).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, pointer, en.
  - Outputs: one-hot gnt and gnt_idx.
  - Implemented as a double-width priority mask.
- The pointer register lives in the parent.

Test Plan:
- Single request: req 2, operand 4'h5, rsp_ready_i=1 -> one cycle with req_ready_o=4'b0100. Two cycles later: rsp_valid_o=1, rsp_id_o=2, rsp_result_o=golden(5).
- All four valid continuously, operands 1,2,3,4, rsp_ready_i=1 -> responses back-to-back with ids 0,1,2,3,0,…; no bubbles; results golden(1..4).
- Stall: two accepted transactions, then rsp_ready_i=0 for 5 cycles -> rsp_* stable, req_ready_o=0. On release, responses arrive in order.
- enable_i=0 with req_valid_i=4'b1111 -> no ready bits, pointer frozen. Raise enable_i -> grant resumes at the frozen pointer.
- Reset asserted mid-stream with S1 and S2 full -> rsp_valid_o=0 and busy_o=0 immediately. After release the first grant goes to requester 0.
- Pointer wrap: N_REQ=4, only req 3 and req 0 valid, pointer at 3 -> grants alternate 3,0,3,0.
